// File: rtl/lsu_agu_frontend_if.sv
// lsu_agu_frontend_if: request/response bundle between the reservation stations, the AGU front end and the LSQ.
// Signals:
//   flush                      pipeline flush (mispredict), driven by the core
//   ch_valid/ch_ready          per-channel request handshake
//   ch_tag/base/imm/sdata/op/size  per-channel micro-op fields (op: 0 = mem_read, 1 = mem_write)
//   out_valid/out_ready        FIFO head handshake toward the LSQ
//   out_tag/addr/data/op/size  FIFO head fields
// Modports: master = RS/LSQ side, slave = front end.
interface lsu_agu_frontend_if #(
    parameter int N_CH   = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                         flush;
    logic [N_CH-1:0]              ch_valid;
    logic [N_CH-1:0]              ch_ready;
    logic [N_CH-1:0][TAG_W-1:0]   ch_tag;
    logic [N_CH-1:0][DATA_W-1:0]  ch_base;
    logic [N_CH-1:0][DATA_W-1:0]  ch_imm;
    logic [N_CH-1:0][DATA_W-1:0]  ch_sdata;
    logic [N_CH-1:0][1:0]         ch_op;
    logic [N_CH-1:0][1:0]         ch_size;
    logic                         out_valid;
    logic                         out_ready;
    logic [TAG_W-1:0]             out_tag;
    logic [ADDR_W-1:0]            out_addr;
    logic [DATA_W-1:0]            out_data;
    logic [1:0]                   out_op;
    logic [1:0]                   out_size;

    modport master (
        output flush, ch_valid, ch_tag, ch_base, ch_imm, ch_sdata, ch_op, ch_size, out_ready,
        input  ch_ready, out_valid, out_tag, out_addr, out_data, out_op, out_size
    );

    modport slave (
        input  flush, ch_valid, ch_tag, ch_base, ch_imm, ch_sdata, ch_op, ch_size, out_ready,
        output ch_ready, out_valid, out_tag, out_addr, out_data, out_op, out_size
    );
endinterface

// File: rtl/lsu_agu_frontend.sv
// lsu_agu_frontend: round-robin RS arbiter, registered base+imm AGU stage and credit-checked output FIFO toward the LSQ.
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous active-low reset
//   bus (slave)      per-channel requests in, FIFO head out, flush
//   misalign_valid   one-cycle pulse for a dropped misaligned half/word access (LSU_AGU_MISALIGN_CHECK_EN only)
//   misalign_tag     tag of that access (LSU_AGU_MISALIGN_CHECK_EN only)
// Build option: define LSU_AGU_MISALIGN_CHECK_EN to drop misaligned accesses in s1 and report them instead.
module lsu_agu_frontend #(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic reset,
    lsu_agu_frontend_if.slave bus
`ifdef LSU_AGU_MISALIGN_CHECK_EN
    ,
    output logic             misalign_valid,
    output logic [TAG_W-1:0] misalign_tag
`endif
);
    localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0]              ptr;
    logic [PW-1:0]              gnt_idx;
    logic [PW-1:0]              cand;
    logic                       gnt_any;
    logic                       hs;
    logic                       space;
    logic                       push;
    logic                       pop;

    logic                       s1_valid;
    logic [TAG_W-1:0]           s1_tag;
    logic [ADDR_W-1:0]          s1_addr;
    logic [DATA_W-1:0]          s1_data;
    logic [1:0]                 s1_op;
    logic [1:0]                 s1_size;

    logic [DEPTH-1:0][TAG_W-1:0]  mem_tag;
    logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data;
    logic [DEPTH-1:0][1:0]        mem_op;
    logic [DEPTH-1:0][1:0]        mem_size;
    logic [AW-1:0]                wptr;
    logic [AW-1:0]                rptr;
    logic [CW-1:0]                count;

    // Scanning from the farthest candidate back toward ptr leaves the first
    // valid channel at or after ptr as the final winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N_CH);
            if (bus.ch_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Credits cover both the FIFO and the AGU stage, so s1 can always write.
    assign space        = (count + CW'(s1_valid)) < CW'(DEPTH);
    assign hs           = gnt_any & space & ~bus.flush & reset;
    assign bus.ch_ready = hs ? N_CH'(1) << gnt_idx : '0;

`ifdef LSU_AGU_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign       = s1_valid && ((s1_size == 2'd1 && s1_addr[0]) ||
                                         (s1_size == 2'd2 && s1_addr[1:0] != 2'b00));
    assign misalign_valid = misalign & ~bus.flush;
    assign misalign_tag   = misalign_valid ? s1_tag : '0;
    assign push           = s1_valid & ~misalign;
`else
    assign push           = s1_valid;
`endif

    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_valid = count != '0;
    assign bus.out_tag   = mem_tag[rptr];
    assign bus.out_addr  = mem_addr[rptr];
    assign bus.out_data  = mem_data[rptr];
    assign bus.out_op    = mem_op[rptr];
    assign bus.out_size  = mem_size[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_op    <= '0;
            s1_size  <= '0;
        end else begin
            s1_valid <= hs;
            if (hs) begin
                ptr     <= (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                s1_tag  <= bus.ch_tag[gnt_idx];
                s1_addr <= bus.ch_base[gnt_idx][ADDR_W-1:0] + bus.ch_imm[gnt_idx][ADDR_W-1:0];
                s1_data <= bus.ch_sdata[gnt_idx];
                s1_op   <= bus.ch_op[gnt_idx];
                s1_size <= bus.ch_size[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            mem_tag  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_op   <= '0;
            mem_size <= '0;
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem_tag[wptr]  <= s1_tag;
                mem_addr[wptr] <= s1_addr;
                mem_data[wptr] <= s1_data;
                mem_op[wptr]   <= s1_op;
                mem_size[wptr] <= s1_size;
                wptr           <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_lsu_agu_frontend.sv
// tb_lsu_agu_frontend: directed and random stimulus against a queue-based occupancy/latency model of the front end.
module tb_lsu_agu_frontend;
    localparam int N_CH   = 3;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam logic [1:0] mem_read  = 2'd0;
    localparam logic [1:0] mem_write = 2'd1;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        op;
        logic [1:0]        size;
        int                born;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_agu_frontend_if #(.N_CH(N_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
`ifdef LSU_AGU_MISALIGN_CHECK_EN
    logic             misalign_valid;
    logic [TAG_W-1:0] misalign_tag;
`endif

    lsu_agu_frontend #(.N_CH(N_CH), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef LSU_AGU_MISALIGN_CHECK_EN
        ,
        .misalign_valid(misalign_valid),
        .misalign_tag(misalign_tag)
`endif
    );

    ent_t             q[$];
    int               ptr = 0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_err = 0;
    bit               mis_pend = 1'b0;
    logic [TAG_W-1:0] mis_tag = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    task automatic set_ch(input int c, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] base,
                          input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] sdata,
                          input logic [1:0] op, input logic [1:0] size);
        bus.ch_valid[c] = 1'b1;
        bus.ch_tag[c]   = tag;
        bus.ch_base[c]  = base;
        bus.ch_imm[c]   = imm;
        bus.ch_sdata[c] = sdata;
        bus.ch_op[c]    = op;
        bus.ch_size[c]  = size;
    endtask

    task automatic rand_ch(input int c);
        set_ch(c, TAG_W'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom_range(0, 2)));
    endtask

    // One clock cycle: inputs are already driven; check outputs against the
    // model, advance the model across the edge, and return at the next negedge.
    task automatic step();
        int              gnt = -1;
        int              occ;
        bit              ov;
        logic [N_CH-1:0] er = '0;
        ent_t            e;
        #1;
        occ = q.size() + int'(mis_pend);
        if (!bus.flush && occ < DEPTH)
            for (int k = 0; k < N_CH; k++)
                if (gnt < 0 && bus.ch_valid[(ptr + k) % N_CH]) gnt = (ptr + k) % N_CH;
        if (gnt >= 0) er[gnt] = 1'b1;
        ov = q.size() > 0 && cyc - q[0].born >= 2;
        chk("ch_ready", 64'(bus.ch_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(ov));
        if (ov) begin
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
            chk("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
            chk("out_data", 64'(bus.out_data), 64'(q[0].data));
            chk("out_op", 64'(bus.out_op), 64'(q[0].op));
            chk("out_size", 64'(bus.out_size), 64'(q[0].size));
        end
`ifdef LSU_AGU_MISALIGN_CHECK_EN
        chk("misalign_valid", 64'(misalign_valid), 64'(mis_pend && !bus.flush));
        if (mis_pend && !bus.flush) chk("misalign_tag", 64'(misalign_tag), 64'(mis_tag));
`endif
        if (bus.flush) begin
            q.delete();
            mis_pend = 1'b0;
        end else begin
            if (ov && bus.out_ready) void'(q.pop_front());
            mis_pend = 1'b0;
            if (gnt >= 0) begin
                e.tag  = bus.ch_tag[gnt];
                e.addr = ADDR_W'(bus.ch_base[gnt] + bus.ch_imm[gnt]);
                e.data = bus.ch_sdata[gnt];
                e.op   = bus.ch_op[gnt];
                e.size = bus.ch_size[gnt];
                e.born = cyc;
                ptr    = (gnt + 1) % N_CH;
`ifdef LSU_AGU_MISALIGN_CHECK_EN
                if (misaligned(e.addr, e.size)) begin
                    mis_pend = 1'b1;
                    mis_tag  = e.tag;
                end else q.push_back(e);
`else
                q.push_back(e);
`endif
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.ch_valid = '1;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_op", 64'(bus.out_op), 64'd0);
        chk("rst_out_size", 64'(bus.out_size), 64'd0);
`ifdef LSU_AGU_MISALIGN_CHECK_EN
        chk("rst_misalign_valid", 64'(misalign_valid), 64'd0);
        chk("rst_misalign_tag", 64'(misalign_tag), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        bus.ch_valid = '0;
        reset        = 1'b1;
        q.delete();
        ptr      = 0;
        mis_pend = 1'b0;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.ch_valid  = '0;
        bus.ch_tag    = '0;
        bus.ch_base   = '0;
        bus.ch_imm    = '0;
        bus.ch_sdata  = '0;
        bus.ch_op     = '0;
        bus.ch_size   = '0;
        @(negedge clk);
        do_reset();

        // single word read on ch0: 2-cycle latency, base + imm
        bus.out_ready = 1'b1;
        set_ch(0, 6'd5, 32'h100, 32'h10, 32'hdead_beef, mem_read, 2'd2);
        step();
        bus.ch_valid = '0;
        step();
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_addr", 64'(bus.out_addr), 64'h110);
        chk("t1_out_tag", 64'(bus.out_tag), 64'd5);
        step();
        step();

        // round robin from ptr 0 with every channel requesting
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < N_CH; c++) rand_ch(c);
            bus.ch_tag[0] = TAG_W'(i * 4);
            bus.ch_tag[1] = TAG_W'(i * 4 + 1);
            bus.ch_tag[2] = TAG_W'(i * 4 + 2);
            #1;
            chk("rr_grant", 64'(bus.ch_ready), 64'(1) << (i % N_CH));
            step();
        end
        bus.ch_valid = '0;
        repeat (6) step();

        // fill with out_ready low, then drain; the fifth request waits for the first pop
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_ch(0);
            bus.ch_size[0] = 2'd0;
            step();
        end
        #1;
        chk("full_ready", 64'(bus.ch_ready), 64'd0);
        chk("full_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_ch(0);
            bus.ch_size[0] = 2'd0;
            step();
        end
        bus.ch_valid = '0;
        repeat (8) step();

        // flush with three queued and one in s1, then a fresh request
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_ch(1);
            bus.ch_size[1] = 2'd0;
            step();
        end
        bus.flush    = 1'b1;
        bus.ch_valid = '1;
        step();
        bus.flush    = 1'b0;
        bus.ch_valid = '0;
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        set_ch(2, 6'd33, 32'h4000, 32'h24, 32'h1234_5678, mem_write, 2'd2);
        step();
        bus.ch_valid = '0;
        step();
        chk("flush_lat_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_lat_addr", 64'(bus.out_addr), 64'h4024);
        bus.out_ready = 1'b1;
        step();
        step();

        // misaligned word store
        do_reset();
        bus.out_ready = 1'b1;
        set_ch(0, 6'd9, 32'h102, 32'h0, 32'hcafe_f00d, mem_write, 2'd2);
        step();
        bus.ch_valid = '0;
`ifdef LSU_AGU_MISALIGN_CHECK_EN
        chk("mis_pulse", 64'(misalign_valid), 64'd1);
        chk("mis_tag", 64'(misalign_tag), 64'd9);
        step();
        chk("mis_once", 64'(misalign_valid), 64'd0);
        step();
        chk("mis_no_out", 64'(bus.out_valid), 64'd0);
`else
        step();
        chk("mis_off_valid", 64'(bus.out_valid), 64'd1);
        chk("mis_off_addr", 64'(bus.out_addr), 64'h102);
`endif
        step();

        // random traffic with flushes, backpressure phases and a mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            bus.ch_valid = '0;
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 2) != 0) rand_ch(c);
            bus.flush = $urandom_range(0, 31) == 0;
            case ((i / 200) % 3)
                0: bus.out_ready = $urandom_range(0, 1) == 1;
                1: bus.out_ready = 1'b1;
                default: bus.out_ready = $urandom_range(0, 9) == 0;
            endcase
            step();
        end
        bus.ch_valid = '0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
